systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 16, meaning array edge length (N).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning SRAM read-address width.
REQ-003 SHALL have parameter TILE_STRIDE, default 32, meaning address offset between consecutive tiles.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port srst, input, 1, meaning reset: synchronous, active-high.
REQ-006 SHALL have ports start (in, 1, request pulse), tile_cnt (in, 8, tiles per job), w_base_addr and d_base_addr (in, ADDR_WIDTH each, first weight and data addresses).
REQ-007 SHALL have ports busy (out, 1) and done (out, 1, one-cycle job-complete pulse).
REQ-008 SHALL have array-side ports alu_start (out, 1), cycle_num (out, 9) and matrix_index (out, 6).
REQ-009 SHALL have SRAM ports sram_ren (out, 1), sram_raddr_w (out, ADDR_WIDTH) and sram_raddr_d (out, ADDR_WIDTH); the same address drives all four banks of each type.
REQ-010 SHALL have writeback ports out_valid (out, 1), out_ready (in, 1) and out_tile (out, 8, index of the tile being drained).

Function
REQ-011 SHALL implement the FSM states IDLE, COMPUTE, DRAIN and DONE, and SHALL drive busy=1 in every state except IDLE.
REQ-012 IDLE: on start=1 with tile_cnt!=0, SHALL latch tile_cnt and both base addresses, clear the tile index, and enter COMPUTE next cycle; start with tile_cnt=0 SHALL be ignored.
REQ-013 start while busy SHALL be ignored, and latched values SHALL NOT change.
REQ-014 COMPUTE: alu_start=1, and cycle_num SHALL count 0..3N-1 (0..47), one step per cycle; after cycle_num=3N-1 the FSM SHALL enter DRAIN with matrix_index=0.
REQ-015 Outside COMPUTE, alu_start=0 and cycle_num=0, so the array holds its accumulators.
REQ-016 sram_ren SHALL be 1 only in COMPUTE with cycle_num<=2N-2, giving 31 reads per tile.
REQ-017 While sram_ren=1, sram_raddr_x SHALL equal x_base + tile*TILE_STRIDE + cycle_num, computed modulo 2^ADDR_WIDTH (wrap-around, no error).
REQ-018 DRAIN: out_valid=1, and matrix_index SHALL increment on each cycle with out_valid&&out_ready; without out_ready it SHALL hold, with outputs stable.
REQ-019 A handshake at matrix_index=2N-2 (30) SHALL end the tile: if tile<tile_cnt-1, tile SHALL increment and the FSM enter COMPUTE with cycle_num=0; otherwise it SHALL enter DONE.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-021 out_tile SHALL equal the current tile index in all states.
REQ-022 Latency SHALL be: start at cycle T gives the first out_valid at T+1+3N (T+49) and, with out_ready held at 1, done at T+1+3N+(2N-1) (T+80).
REQ-023 matrix_index SHALL be 0 in every state except DRAIN.

Reset
REQ-024 With srst=1 at a clock edge, the next state SHALL be IDLE, with busy, done, alu_start, sram_ren and out_valid all 0, and cycle_num, matrix_index, out_tile, both addresses and the latched registers all 0.
REQ-025 Reset mid-job SHALL abandon the job with no done pulse; a new start is accepted on the first non-reset cycle.

Configuration
REQ-026 With SYSTOLIC_CTRL_PERF_EN defined, the block SHALL add output stall_cycles (16 bits), which clears on accepted start, counts cycles with out_valid&&!out_ready, and saturates at 0xFFFF.
REQ-027 Without SYSTOLIC_CTRL_PERF_EN, the stall_cycles port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package systolic_pkg SHALL hold ARRAY_SIZE, COMPUTE_CYCLES (3N), FEED_CYCLES (2N-1), DIAG_NUM (2N-1) and the FSM state enum type.
REQ-029 The address arithmetic (base latch, tile offset, modulo add) SHALL be one sub-module, systolic_addr_gen, instantiated once per operand (weight, data).

Verification
REQ-030 Scenario: tile_cnt=1, bases 0/0, out_ready=1, start at T -> alu_start high T+1..T+48; sram_ren high T+1..T+31 with addresses 0..30; out_valid high T+49..T+79 with matrix_index 0..30; done at T+80; busy low at T+81.
REQ-031 Scenario: tile_cnt=2, w_base=100 -> second COMPUTE reads weight addresses 132..162; out_tile=1 during the second DRAIN; done comes after 62 total beats.
REQ-032 Scenario: w_base=1020, ADDR_WIDTH=10 -> tile 0 weight addresses are 1020..1023, then 0..26.
REQ-033 Scenario: out_ready low for 5 cycles at matrix_index=7 -> matrix_index holds at 7 and out_valid stays 1; with PERF_EN, stall_cycles=5.
REQ-034 Scenario: start re-pulsed during COMPUTE with tile_cnt=9 -> ignored; the job runs its original count. Separately, start with tile_cnt=0 -> busy stays 0.
REQ-035 Scenario: srst at cycle_num=20 -> next cycle all outputs 0 and state IDLE; no done pulse; a later start restarts at cycle_num=0 with tile 0 addresses.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants, helper functions and FSM state type for the systolic array controller.
// Used by systolic_ctrl and systolic_addr_gen.
package systolic_pkg;

    localparam int ARRAY_SIZE     = 16;
    localparam int COMPUTE_CYCLES = 3 * ARRAY_SIZE;
    localparam int FEED_CYCLES    = 2 * ARRAY_SIZE - 1;
    localparam int DIAG_NUM       = 2 * ARRAY_SIZE - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Derived counts for an arbitrary edge length, so the top can be re-parameterised.
    function automatic int compute_cycles(input int n);
        return 3 * n;
    endfunction

    function automatic int feed_cycles(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int diag_num(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_addr_gen.sv
// SRAM read-address generator for one operand: latches the job base address and forms
// base + tile*TILE_STRIDE + cycle modulo 2^ADDR_WIDTH.
module systolic_addr_gen
    import systolic_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int TILE_STRIDE = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [7:0]            tile_i,
    input  logic [8:0]            cycle_i,
    input  logic                  en_i,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] base_d;
    logic [ADDR_WIDTH-1:0] tile_off;
    logic [ADDR_WIDTH-1:0] sum;

    always_comb begin
        base_d = base_q;
        if (load_i) begin
            base_d = base_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    // All terms are kept at ADDR_WIDTH so the sum wraps naturally.
    assign tile_off = ADDR_WIDTH'(tile_i) * ADDR_WIDTH'(TILE_STRIDE);
    assign sum      = base_q + tile_off + ADDR_WIDTH'(cycle_i);
    assign addr_o   = en_i ? sum : '0;

endmodule

// File: rtl/systolic_ctrl.sv
// Systolic array job controller: per tile runs a 3N-cycle COMPUTE phase with SRAM feeding,
// then a 2N-1 beat DRAIN over a valid/ready writeback port. Optional stall counter under SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
    parameter int ARRAY_SIZE  = systolic_pkg::ARRAY_SIZE,
    parameter int ADDR_WIDTH  = 10,
    parameter int TILE_STRIDE = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  start,
    input  logic [7:0]            tile_cnt,
    input  logic [ADDR_WIDTH-1:0] w_base_addr,
    input  logic [ADDR_WIDTH-1:0] d_base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  alu_start,
    output logic [8:0]            cycle_num,
    output logic [5:0]            matrix_index,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_raddr_w,
    output logic [ADDR_WIDTH-1:0] sram_raddr_d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_tile,
`ifdef SYSTOLIC_CTRL_PERF_EN
    output logic [15:0]           stall_cycles,
`endif
    output systolic_pkg::state_t  dbg_state
);

    import systolic_pkg::*;

    localparam logic [8:0] LAST_CYCLE = 9'(compute_cycles(ARRAY_SIZE) - 1);
    localparam logic [8:0] LAST_FEED  = 9'(feed_cycles(ARRAY_SIZE) - 1);
    localparam logic [5:0] LAST_DIAG  = 6'(diag_num(ARRAY_SIZE) - 1);

    state_t     state_q, state_d;
    logic [8:0] cycle_q, cycle_d;
    logic [5:0] midx_q, midx_d;
    logic [7:0] tile_q, tile_d;
    logic [7:0] tile_cnt_q, tile_cnt_d;
    logic       accept;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= IDLE;
            cycle_q    <= '0;
            midx_q     <= '0;
            tile_q     <= '0;
            tile_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            midx_q     <= midx_d;
            tile_q     <= tile_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    // Writeback handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // while out_ready is low, out_valid, matrix_index and out_tile hold steady.
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        midx_d     = midx_q;
        tile_d     = tile_q;
        tile_cnt_d = tile_cnt_q;
        accept     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        alu_start  = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start && (tile_cnt != 8'd0)) begin
                    accept     = 1'b1;
                    tile_cnt_d = tile_cnt;
                    tile_d     = '0;
                    cycle_d    = '0;
                    midx_d     = '0;
                    state_d    = COMPUTE;
                end
            end
            COMPUTE: begin
                alu_start = 1'b1;
                if (cycle_q == LAST_CYCLE) begin
                    cycle_d = '0;
                    midx_d  = '0;
                    state_d = DRAIN;
                end else begin
                    cycle_d = cycle_q + 9'd1;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (midx_q == LAST_DIAG) begin
                        midx_d = '0;
                        if (({1'b0, tile_q} + 9'd1) < {1'b0, tile_cnt_q}) begin
                            tile_d  = tile_q + 8'd1;
                            state_d = COMPUTE;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        midx_d = midx_q + 6'd1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cycle_num    = alu_start ? cycle_q : '0;
    assign matrix_index = out_valid ? midx_q : '0;
    assign sram_ren     = (state_q == COMPUTE) && (cycle_q <= LAST_FEED);
    assign out_tile     = tile_q;
    assign dbg_state    = state_q;

    systolic_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TILE_STRIDE (TILE_STRIDE)
    ) u_addr_w (
        .clk     (clk),
        .srst    (srst),
        .load_i  (accept),
        .base_i  (w_base_addr),
        .tile_i  (tile_q),
        .cycle_i (cycle_q),
        .en_i    (sram_ren),
        .addr_o  (sram_raddr_w)
    );

    systolic_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TILE_STRIDE (TILE_STRIDE)
    ) u_addr_d (
        .clk     (clk),
        .srst    (srst),
        .load_i  (accept),
        .base_i  (d_base_addr),
        .tile_i  (tile_q),
        .cycle_i (cycle_q),
        .en_i    (sram_ren),
        .addr_o  (sram_raddr_d)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: randomized jobs checked against a queue-based
// model of the expected ALU cycles, SRAM addresses and drain beats.
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int N        = 16;
    localparam int AW       = 10;
    localparam int STRIDE   = 32;
    localparam int COMP     = 3 * N;
    localparam int FEED     = 2 * N - 1;
    localparam int DIAG     = 2 * N - 1;
    localparam int TILE_CYC = COMP + DIAG;

    logic          clk;
    logic          srst;
    logic          start;
    logic [7:0]    tile_cnt;
    logic [AW-1:0] w_base_addr;
    logic [AW-1:0] d_base_addr;
    logic          busy;
    logic          done;
    logic          alu_start;
    logic [8:0]    cycle_num;
    logic [5:0]    matrix_index;
    logic          sram_ren;
    logic [AW-1:0] sram_raddr_w;
    logic [AW-1:0] sram_raddr_d;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_tile;
    state_t        dbg_state;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0]   stall_cycles;
`endif

    int checks;
    int errors;

    logic [8:0]    exp_cyc_q[$];
    logic [AW-1:0] exp_w_q[$];
    logic [AW-1:0] exp_d_q[$];
    logic [13:0]   exp_beat_q[$];

    systolic_ctrl #(
        .ARRAY_SIZE  (N),
        .ADDR_WIDTH  (AW),
        .TILE_STRIDE (STRIDE)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .start        (start),
        .tile_cnt     (tile_cnt),
        .w_base_addr  (w_base_addr),
        .d_base_addr  (d_base_addr),
        .busy         (busy),
        .done         (done),
        .alu_start    (alu_start),
        .cycle_num    (cycle_num),
        .matrix_index (matrix_index),
        .sram_ren     (sram_ren),
        .sram_raddr_w (sram_raddr_w),
        .sram_raddr_d (sram_raddr_d),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tile     (out_tile),
`ifdef SYSTOLIC_CTRL_PERF_EN
        .stall_cycles (stall_cycles),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job from the current negedge. mode 0: ready always 1; mode 1: random ready;
    // mode 2: ready dropped for 5 cycles when matrix_index first reaches 7.
    // repulse_k > 0 re-pulses start with tile_cnt=9 at that cycle offset.
    task automatic run_job(input int tiles, input int wb, input int db, input int mode,
                           input int repulse_k, output int stalls);
        int          k;
        int          done_k;
        int          first_valid_k;
        int          stall_left;
        bit          stall_used;
        int          budget;
        logic [13:0] got_beat;
        exp_cyc_q.delete();
        exp_w_q.delete();
        exp_d_q.delete();
        exp_beat_q.delete();
        for (int t = 0; t < tiles; t++) begin
            for (int c = 0; c < COMP; c++) exp_cyc_q.push_back(9'(c));
            for (int c = 0; c < FEED; c++) begin
                exp_w_q.push_back(AW'((wb + t * STRIDE + c) % (1 << AW)));
                exp_d_q.push_back(AW'((db + t * STRIDE + c) % (1 << AW)));
            end
            for (int i = 0; i < DIAG; i++) exp_beat_q.push_back(14'(t * 64 + i));
        end
        start       = 1'b1;
        tile_cnt    = 8'(tiles);
        w_base_addr = AW'(wb);
        d_base_addr = AW'(db);
        out_ready   = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        tile_cnt    = 8'($urandom);
        w_base_addr = AW'($urandom);
        d_base_addr = AW'($urandom);
        k = 1; done_k = 0; first_valid_k = 0; stall_left = 0; stall_used = 0; stalls = 0;
        budget = TILE_CYC * tiles + 400;
        while (done_k == 0 && k <= budget) begin
            // drive inputs for the upcoming edge
            start    = (repulse_k > 0 && k == repulse_k);
            tile_cnt = start ? 8'd9 : tile_cnt;
            if (stall_left > 0) begin
                out_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else if (mode == 2 && !stall_used && out_valid && matrix_index == 6'd7) begin
                out_ready  = 1'b0;
                stall_left = 4;
                stall_used = 1'b1;
            end else if (mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            // compare against the model
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_job k=%0d got=%b want=1", k, busy);
            end
            if (alu_start) begin
                checks++;
                if (exp_cyc_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_alu k=%0d got cycle_num=%0d want none", k, cycle_num);
                end else if (cycle_num !== exp_cyc_q.pop_front()) begin
                    errors++;
                    $display("FAIL cycle_num k=%0d got=%0d", k, cycle_num);
                end
            end else begin
                checks++;
                if (cycle_num !== 9'd0) begin
                    errors++;
                    $display("FAIL cycle_num_idle k=%0d got=%0d want=0", k, cycle_num);
                end
            end
            if (sram_ren) begin
                checks++;
                if (exp_w_q.size() == 0 || !alu_start) begin
                    errors++;
                    $display("FAIL extra_sram_read k=%0d got ren=1 want ren=0", k);
                end else if (sram_raddr_w !== exp_w_q[0] || sram_raddr_d !== exp_d_q[0]) begin
                    errors++;
                    $display("FAIL sram_addr k=%0d got w=%0d d=%0d want w=%0d d=%0d",
                             k, sram_raddr_w, sram_raddr_d, exp_w_q[0], exp_d_q[0]);
                    void'(exp_w_q.pop_front());
                    void'(exp_d_q.pop_front());
                end else begin
                    void'(exp_w_q.pop_front());
                    void'(exp_d_q.pop_front());
                end
            end
            if (out_valid) begin
                if (first_valid_k == 0) first_valid_k = k;
                got_beat = {out_tile, matrix_index};
                checks++;
                if (exp_beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat k=%0d got tile=%0d idx=%0d want none",
                             k, out_tile, matrix_index);
                end else if (got_beat !== exp_beat_q[0]) begin
                    errors++;
                    $display("FAIL drain_beat k=%0d got tile=%0d idx=%0d want tile=%0d idx=%0d",
                             k, out_tile, matrix_index, exp_beat_q[0][13:6], exp_beat_q[0][5:0]);
                end
                if (out_ready && exp_beat_q.size() != 0) void'(exp_beat_q.pop_front());
                if (!out_ready) stalls++;
            end else begin
                checks++;
                if (matrix_index !== 6'd0) begin
                    errors++;
                    $display("FAIL matrix_index_idle k=%0d got=%0d want=0", k, matrix_index);
                end
            end
            if (done) done_k = k;
            @(negedge clk);
            k++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (done_k == 0) begin
            errors++;
            $display("FAIL done_timeout got no done within %0d cycles want done", budget);
        end else if (done_k != TILE_CYC * tiles + 1 + stalls) begin
            errors++;
            $display("FAIL done_latency got=%0d want=%0d", done_k, TILE_CYC * tiles + 1 + stalls);
        end
        checks++;
        if (exp_cyc_q.size() + exp_w_q.size() + exp_beat_q.size() != 0) begin
            errors++;
            $display("FAIL job_incomplete got leftover alu=%0d rd=%0d beats=%0d want 0",
                     exp_cyc_q.size(), exp_w_q.size(), exp_beat_q.size());
        end
        if (mode == 0) begin
            checks++;
            if (first_valid_k != COMP + 1) begin
                errors++;
                $display("FAIL first_valid got=%0d want=%0d", first_valid_k, COMP + 1);
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL after_done got busy=%b done=%b state=%0d want 0 0 IDLE",
                     busy, done, dbg_state);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; start = 1'b0; tile_cnt = 8'd0;
        w_base_addr = '0; d_base_addr = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, alu_start, sram_ren, out_valid, cycle_num, matrix_index, out_tile,
             sram_raddr_w, sram_raddr_d} !== 48'd0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b ren=%b valid=%b state=%0d want all 0",
                     busy, sram_ren, out_valid, dbg_state);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall got=%0d want=0", stall_cycles);
        end
`endif
        srst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_tile();
        int s;
        run_job(1, 0, 0, 0, 0, s);
    endtask

    task automatic test_multi_tile();
        int s;
        run_job(2, 100, int'($urandom_range(0, 1023)), 0, 0, s);
    endtask

    task automatic test_wrap();
        int s;
        run_job(1, 1020, int'($urandom_range(1000, 1023)), 0, 0, s);
    endtask

    task automatic test_stall();
        int s;
        run_job(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 2, 0, s);
        checks++;
        if (s != 5) begin
            errors++;
            $display("FAIL stall_count got=%0d want=5", s);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL stall_cycles got=%0d want=5", stall_cycles);
        end
`endif
    endtask

    task automatic test_ignore_start();
        int s;
        run_job(2, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 10, s);
    endtask

    task automatic test_zero_tile();
        start = 1'b1; tile_cnt = 8'd0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || dbg_state !== IDLE) begin
                errors++;
                $display("FAIL zero_tile i=%0d got busy=%b state=%0d want 0 IDLE", i, busy, dbg_state);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_jobs();
        int s;
        for (int j = 0; j < 4; j++) begin
            run_job(int'($urandom_range(1, 3)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)), 1, 0, s);
`ifdef SYSTOLIC_CTRL_PERF_EN
            checks++;
            if (stall_cycles !== 16'(s)) begin
                errors++;
                $display("FAIL random_stall job=%0d got=%0d want=%0d", j, stall_cycles, s);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        int  s;
        bit  hit;
        start = 1'b1; tile_cnt = 8'd2;
        w_base_addr = AW'($urandom); d_base_addr = AW'($urandom); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (alu_start && cycle_num == 9'd20) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reset_reach got no cycle_num=20 want reached");
        end
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        checks++;
        if ({busy, done, alu_start, sram_ren, out_valid, cycle_num, matrix_index, out_tile,
             sram_raddr_w, sram_raddr_d} !== 48'd0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset_outputs got busy=%b done=%b cyc=%0d state=%0d want all 0",
                     busy, done, cycle_num, dbg_state);
        end
        run_job(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 0, s);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_wrap();
        test_stall();
        test_ignore_start();
        test_zero_tile();
        test_random_jobs();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
